note_history_ctrl: RTL and testbench
====================================

Name: note_history_ctrl

Overview:
- Sequencer that owns the note-overlay configuration. It captures note-start events from the music player and keeps a DEPTH-entry history: entry 0 is the current note, entry 1 is the previous note, and so on.
- History updates are committed only at frame boundaries, so note_display instances never tear mid-frame.
- Outputs drive the note/num/symbol inputs and the overlay-enable logic in wave_display_top.

Parameters:
- DEPTH, 4, number of history entries (2..8).
- HOLD_FRAMES, 60, idle frames after the last commit before the history is blanked.
- NOTE_W, 6, note code width; code 0 means rest.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- note_start  input  1  one-cycle pulse, a new note begins
- note  input  NOTE_W  note code, sampled when note_start=1
- vsync  input  1  VGA vsync; frame boundary = registered 1->0 transition
- freeze  input  1  music player paused: hold history, stop aging
- clear_hist  input  1  synchronous clear request
- hist_notes  output  DEPTH*NOTE_W  entry i at bits [i*NOTE_W +: NOTE_W]
- hist_valid  output  DEPTH  per-entry display enable
- pending  output  1  a captured note awaits commit
- drop_cnt  output  8  saturating count of overwritten pending notes
- frame_tick  output  1  one-cycle pulse on each detected frame boundary

Behaviour:
- Reset (reset=0, asynchronous):
  - hist_notes=0, hist_valid=0, pending=0, drop_cnt=0, frame_tick=0.
  - FSM goes to IDLE; idle frame counter=0; vsync_q=0.
- Frame boundary: vsync_q registered each cycle; boundary = vsync_q & ~vsync. frame_tick is asserted the same cycle the boundary is detected (one cycle after vsync falls).
- Capture:
  - note_start with note==0 (rest) is ignored.
  - Otherwise the note is loaded into the pending register, pending=1.
  - A capture while pending=1 overwrites the pending register and increments drop_cnt, which saturates at 255.
  - A repeated identical note is a new event.
- FSM states IDLE, PEND, COMMIT:
  - IDLE -> PEND on capture.
  - PEND -> COMMIT on frame boundary with freeze=0.
  - COMMIT lasts 1 cycle and returns to IDLE, or to PEND if a capture occurs in that same cycle.
- COMMIT actions:
  - Shift history: entry i <= entry i-1 for i=DEPTH-1..1. Entry 0 <= pending note.
  - hist_valid <= {hist_valid[DEPTH-2:0],1}. pending=0 unless a new capture lands in the COMMIT cycle.
  - Idle counter=0.
  - Commit latency: note visible on hist_notes 2 cycles after the boundary cycle.
- Aging:
  - In IDLE with freeze=0, each boundary increments the idle counter, saturating at HOLD_FRAMES.
  - The boundary on which the counter reaches HOLD_FRAMES clears hist_valid to 0. hist_notes are retained.
- freeze=1: no commits, no aging. Captures still accepted into pending.
- clear_hist=1 (any state): next cycle hist_notes=0, hist_valid=0, pending=0, idle counter=0, FSM=IDLE. drop_cnt is kept.
  - clear_hist has priority over a simultaneous capture or commit; that capture is discarded and not counted.
- Boundary and capture in the same cycle while in IDLE: the capture goes to pending and is committed at the next boundary, not the current one.
- Counter width: ceil(log2(HOLD_FRAMES+1)).

Decomposition:
- Shared package note_ui_pkg holds:
  - NOTE_W and NOTE_REST=0.
  - FSM state encoding (IDLE=2'd0, PEND=2'd1, COMMIT=2'd2).
  - Default HOLD_FRAMES.
- One natural sub-module: frame_edge_det (vsync register plus falling-edge pulse), reused by other overlay controllers.
- History shift register and FSM stay in the top.

Test Plan:
- Reset-then-single-note:
  - Stimulus: release reset, pulse note_start with note=6'd13, then drop vsync.
  - Response: pending=1 until the boundary; 2 cycles after the boundary hist_notes[5:0]=13, hist_valid=4'b0001, pending=0.
- History shift:
  - Stimulus: commit notes 5, 9, 12, 20, 33 on successive frames.
  - Response: entries 0..3 = 33, 20, 12, 9; hist_valid=4'b1111.
- Overwrite and rest:
  - Stimulus: within one frame send note 7, note 0, note 8.
  - Response: commit loads 8; drop_cnt=1 (the rest is ignored, not counted). Also drive 300 overwrites and check drop_cnt saturates at 255.
- Aging and freeze:
  - Aging: with HOLD_FRAMES=3, commit one note then 3 idle boundaries; hist_valid=0 after the 3rd.
  - Freeze: repeat with freeze=1; hist_valid is held and the pending note is not committed until freeze=0 and the next boundary.
- Simultaneous events:
  - Capture in the COMMIT cycle: FSM returns to PEND, and that note commits at the following boundary.
  - clear_hist with a capture in the same cycle: all outputs except drop_cnt are 0 and pending=0.
- Asynchronous reset mid-PEND:
  - Stimulus: assert reset between clock edges.
  - Response: outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/note_ui_pkg.sv
// Shared constants and state encoding for the note-overlay controllers.
package note_ui_pkg;

  localparam int unsigned NOTE_W          = 6;
  localparam int unsigned NOTE_REST       = 0;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned HOLD_FRAMES_DEF = 60;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPend   = 2'd1,
    StCommit = 2'd2
  } hist_state_e;

endpackage

// File: rtl/frame_edge_det.sv
// Registers vsync and flags the falling edge as a frame boundary.
module frame_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q, vsync_d;

  always_comb begin
    vsync_d = vsync_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
    end
  end

  // Combinational so the tick lines up with the cycle vsync is first seen low.
  assign tick_o = vsync_q & ~vsync_i;

endmodule

// File: rtl/note_history_ctrl.sv
// Captures note-start events and commits them into a shift-register history on
// frame boundaries so the overlay never changes mid-frame.
module note_history_ctrl #(
  parameter int unsigned DEPTH       = note_ui_pkg::DEPTH_DEF,
  parameter int unsigned HOLD_FRAMES = note_ui_pkg::HOLD_FRAMES_DEF,
  parameter int unsigned NOTE_W      = note_ui_pkg::NOTE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    note_start,
  input  logic [NOTE_W-1:0]       note,
  input  logic                    vsync,
  input  logic                    freeze,
  input  logic                    clear_hist,
  output logic [DEPTH*NOTE_W-1:0] hist_notes,
  output logic [DEPTH-1:0]        hist_valid,
  output logic                    pending,
  output logic [7:0]              drop_cnt,
  output logic                    frame_tick
);

  import note_ui_pkg::*;

  localparam int unsigned CntW  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned HistW = DEPTH * NOTE_W;

  hist_state_e state_q, state_d;

  logic [HistW-1:0]  hist_q, hist_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [NOTE_W-1:0] pend_note_q, pend_note_d;
  logic              pending_q, pending_d;
  logic [7:0]        drop_q, drop_d;
  logic [CntW-1:0]   idle_q, idle_d;

  logic boundary;
  logic capture;
  logic commit_en;
  logic age_en;

  frame_edge_det u_frame_edge_det (
    .clk_i   (clk),
    .rst_ni  (reset),
    .vsync_i (vsync),
    .tick_o  (boundary)
  );

  // A clear request swallows any capture in the same cycle.
  assign capture = note_start & (note != NOTE_W'(NOTE_REST)) & ~clear_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_hist) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (capture) state_d = StPend;
        StPend:   if (boundary && !freeze) state_d = StCommit;
        StCommit: state_d = capture ? StPend : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    commit_en = (state_q == StCommit) & ~clear_hist;
    age_en    = (state_q == StIdle) & boundary & ~freeze & ~clear_hist;
  end

  always_comb begin
    hist_d      = hist_q;
    valid_d     = valid_q;
    pend_note_d = pend_note_q;
    pending_d   = pending_q;
    drop_d      = drop_q;
    idle_d      = idle_q;

    if (clear_hist) begin
      hist_d      = '0;
      valid_d     = '0;
      pend_note_d = '0;
      pending_d   = 1'b0;
      idle_d      = '0;
    end else begin
      if (commit_en) begin
        hist_d    = {hist_q[HistW-NOTE_W-1:0], pend_note_q};
        valid_d   = {valid_q[DEPTH-2:0], 1'b1};
        pending_d = 1'b0;
        idle_d    = '0;
      end

      if (age_en && (idle_q != CntW'(HOLD_FRAMES))) begin
        idle_d = idle_q + CntW'(1);
        if (idle_d == CntW'(HOLD_FRAMES)) begin
          valid_d = '0;
        end
      end

      if (capture) begin
        pend_note_d = note;
        pending_d   = 1'b1;
        // The note pending during COMMIT is being committed, so it is not lost.
        if (pending_q && !commit_en && (drop_q != 8'hFF)) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q      <= '0;
      valid_q     <= '0;
      pend_note_q <= '0;
      pending_q   <= 1'b0;
      drop_q      <= '0;
      idle_q      <= '0;
    end else begin
      hist_q      <= hist_d;
      valid_q     <= valid_d;
      pend_note_q <= pend_note_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      idle_q      <= idle_d;
    end
  end

  assign hist_notes = hist_q;
  assign hist_valid = valid_q;
  assign pending    = pending_q;
  assign drop_cnt   = drop_q;
  assign frame_tick = boundary;

endmodule

// File: tb/tb_note_history_ctrl.sv
// Directed bench for note_history_ctrl with a short hold time for aging.
module tb_note_history_ctrl;

  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 3;
  localparam int unsigned NoteW = 6;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    note_start = 1'b0;
  logic [NoteW-1:0]        note = '0;
  logic                    vsync = 1'b0;
  logic                    freeze = 1'b0;
  logic                    clear_hist = 1'b0;
  logic [Depth*NoteW-1:0]  hist_notes;
  logic [Depth-1:0]        hist_valid;
  logic                    pending;
  logic [7:0]              drop_cnt;
  logic                    frame_tick;

  int checks = 0;
  int failures = 0;

  note_history_ctrl #(
    .DEPTH       (Depth),
    .HOLD_FRAMES (Hold),
    .NOTE_W      (NoteW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note_start (note_start),
    .note       (note),
    .vsync      (vsync),
    .freeze     (freeze),
    .clear_hist (clear_hist),
    .hist_notes (hist_notes),
    .hist_valid (hist_valid),
    .pending    (pending),
    .drop_cnt   (drop_cnt),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_note(input logic [NoteW-1:0] n);
    note_start = 1'b1;
    note       = n;
    tick();
    note_start = 1'b0;
    note       = '0;
  endtask

  // Leaves vsync low with the boundary asserted in the current cycle.
  task automatic boundary();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    #1;
  endtask

  task automatic commit_frame();
    boundary();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 1'b0;
    #20;
    check_eq("rst_hist", hist_notes, 0);
    check_eq("rst_valid", hist_valid, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_tick", frame_tick, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Single note
    send_note(6'd13);
    check_eq("single_pend", pending, 1);
    boundary();
    check_eq("single_tick", frame_tick, 1);
    check_eq("single_pend_at_bnd", pending, 1);
    tick();
    check_eq("single_tick_gone", frame_tick, 0);
    check_eq("single_not_yet", hist_notes[5:0], 0);
    tick();
    check_eq("single_note", hist_notes[5:0], 13);
    check_eq("single_valid", hist_valid, 4'b0001);
    check_eq("single_pend_clr", pending, 0);

    // History shift
    send_note(6'd5);  commit_frame();
    send_note(6'd9);  commit_frame();
    send_note(6'd12); commit_frame();
    send_note(6'd20); commit_frame();
    send_note(6'd33); commit_frame();
    check_eq("shift_hist", hist_notes, {6'd9, 6'd12, 6'd20, 6'd33});
    check_eq("shift_valid", hist_valid, 4'b1111);

    // Overwrite and rest
    send_note(6'd7);
    send_note(6'd0);
    send_note(6'd8);
    check_eq("ovw_drop", drop_cnt, 1);
    commit_frame();
    check_eq("ovw_entry0", hist_notes[5:0], 8);
    check_eq("ovw_entry1", hist_notes[11:6], 33);

    // Clear with simultaneous capture while pending
    send_note(6'd3);
    check_eq("clr_pre_pend", pending, 1);
    clear_hist = 1'b1;
    note_start = 1'b1;
    note       = 6'd44;
    tick();
    clear_hist = 1'b0;
    note_start = 1'b0;
    check_eq("clr_hist", hist_notes, 0);
    check_eq("clr_valid", hist_valid, 0);
    check_eq("clr_pending", pending, 0);
    check_eq("clr_drop", drop_cnt, 1);
    commit_frame();
    check_eq("clr_no_commit", hist_valid, 0);

    // Aging
    send_note(6'd21);
    commit_frame();
    check_eq("age_start", hist_valid, 4'b0001);
    for (int k = 1; k <= 3; k++) begin
      boundary();
      tick();
      check_eq($sformatf("age_%0d", k), hist_valid, (k < 3) ? 4'b0001 : 4'b0000);
    end
    check_eq("age_notes_kept", hist_notes[5:0], 21);

    // Freeze
    send_note(6'd22);
    commit_frame();
    check_eq("frz_start", hist_valid, 4'b0001);
    freeze = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      boundary();
      tick();
      check_eq($sformatf("frz_hold_%0d", k), hist_valid, 4'b0001);
    end
    send_note(6'd23);
    commit_frame();
    check_eq("frz_no_commit", hist_notes[5:0], 22);
    check_eq("frz_pending", pending, 1);
    freeze = 1'b0;
    commit_frame();
    check_eq("frz_commit", hist_notes[5:0], 23);
    check_eq("frz_valid", hist_valid, 4'b0011);
    check_eq("frz_pend_clr", pending, 0);

    // Capture in the COMMIT cycle
    send_note(6'd40);
    boundary();
    tick();
    send_note(6'd41);
    check_eq("cc_entry0", hist_notes[5:0], 40);
    check_eq("cc_pending", pending, 1);
    commit_frame();
    check_eq("cc_next", hist_notes[11:0], {6'd40, 6'd41});
    check_eq("cc_valid", hist_valid, 4'b1111);
    check_eq("cc_pend_clr", pending, 0);

    // Capture on the same cycle as a boundary in IDLE
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    send_note(6'd50);
    tick();
    check_eq("sb_no_commit", hist_notes[5:0], 41);
    check_eq("sb_pending", pending, 1);
    commit_frame();
    check_eq("sb_commit", hist_notes[11:0], {6'd41, 6'd50});

    // Drop counter saturation
    repeat (300) send_note(6'd2);
    check_eq("sat_drop", drop_cnt, 255);
    check_eq("sat_pending", pending, 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("areset_pending", pending, 0);
    check_eq("areset_hist", hist_notes, 0);
    check_eq("areset_valid", hist_valid, 0);
    check_eq("areset_drop", drop_cnt, 0);
    check_eq("areset_tick", frame_tick, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_eq("post_reset_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
